piso_shift_reg: RTL and testbench
=================================

Name: piso_shift_reg

Overview:
Parallel-in, serial-out shifter. It is the transmit-side counterpart of the serial-in, parallel-out shift register: it accepts an MSB-bit word through a valid/ready load handshake and emits it one bit per enabled clock on a serial output. The shift direction is latched per word. It sits ahead of any serial link whose far end is a `shift_reg` deserializer with a matching `dir`.

Parameters:
MSB, 16, word width in bits; legal range >= 2. Counter width is $clog2(MSB).

Ports:
clk  input  1  system clock, rising-edge
rstn  input  1  asynchronous active-low reset
en  input  1  shift enable; when 0 the in-flight word holds
dir  input  1  direction, sampled at load only: 0 = MSB-first (shift left), 1 = LSB-first (shift right)
load_valid  input  1  load_data is presented
load_ready  output  1  block accepts a word this cycle
load_data  input  MSB  parallel word to serialize
q  output  1  serial data bit
q_valid  output  1  q carries a valid bit of the current word
last  output  1  q is the final bit of the word
busy  output  1  word in flight (state SHIFT)

Behaviour:
- Clocking and reset: single clock domain, clk only. rstn is asynchronous assert, synchronous deassert handled externally.
- Reset values: state=IDLE, shreg=0, cnt=0, dir_q=0. Outputs: q=0, q_valid=0, last=0, busy=0, load_ready=1.
- Registers:
  - shreg[MSB-1:0] holds the word being shifted.
  - cnt counts bits already shifted out.
  - dir_q holds the direction latched at load.
  - state is IDLE or SHIFT.
- Output decode:
  - q = dir_q ? shreg[0] : shreg[MSB-1] in SHIFT; q = 0 in IDLE.
  - q_valid = busy = (state==SHIFT).
  - last = q_valid && (cnt==MSB-1).
  - load_ready = (state==IDLE) || (state==SHIFT && en && last). This is combinational from state, cnt and en.
- Accept: a word is accepted when load_valid && load_ready at a rising clk edge. On accept:
  - shreg <= load_data, dir_q <= dir, cnt <= 0, state <= SHIFT.
  - The first bit appears on q in the cycle after accept. Latency is 1 clk.
- SHIFT with en=1, not last:
  - dir_q=0: shreg <= {shreg[MSB-2:0],1'b0}.
  - dir_q=1: shreg <= {1'b0,shreg[MSB-1:1]}.
  - cnt <= cnt+1.
  - Vacated bits fill with 0.
- SHIFT with en=1 and last:
  - If load_valid=1: back-to-back accept per the accept rule. There is no idle bubble, and q_valid stays 1.
  - If load_valid=0: state <= IDLE, cnt <= 0, shreg <= 0.
- SHIFT with en=0: all registers hold, q is stable, load_ready=0 (including while last=1).
- IDLE with en: en has no effect. The block waits for load_valid only.
- dir changes mid-word are ignored; only dir_q steers the current word.
- load_data and load_valid are ignored whenever load_ready=0. No word is dropped or overwritten in flight.
- A full word takes exactly MSB enabled cycles in SHIFT. last is asserted on exactly one enabled beat per word.
- Reset mid-word aborts the word immediately (asynchronously). Outputs return to reset values, and the next accept starts a fresh word.

Test Plan:
- Reset, then load 16'hA5C3 with dir=0 and en held 1 -> q over 16 cycles = 1010010111000011, last high only on the 16th beat, then busy=0 and load_ready=1.
- Load 16'hA5C3 with dir=1 and en=1 -> q = 1100001110100101 (LSB-first), last on the 16th beat.
- Load 16'hFFFF with dir=0, then toggle en 1/0 every cycle -> q stays 1 for 16 enabled beats (32 clks), cnt holds while en=0, and load_ready stays 0 until the last enabled beat.
- Back-to-back: load 16'h8001, then keep load_valid=1 with 16'h0001 -> second word begins the cycle after the first word's last beat, q_valid never drops, and q stream = 1000000000000001 followed by 0000000000000001.
- Toggle dir 0->1 at beat 5 of 16'hA5C3 -> output identical to the dir=0 sequence. Start a new word with dir=1 -> LSB-first sequence.
- Assert rstn=0 at beat 7 of a word -> q=0, q_valid=0, busy=0 and load_ready=1 immediately. After release, a load of 16'h00FF (dir=0) -> eight 0s then eight 1s.

Source files
------------

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shifter with a valid/ready load port.
// The shift direction is latched per word. When the last bit of a word is
// shifted out with enable high, a waiting word is accepted on the same edge,
// so consecutive words stream with no idle cycle between them.
module piso_shift_reg #(
  parameter int unsigned MSB = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           dir,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [MSB-1:0] load_data,
  output logic           q,
  output logic           q_valid,
  output logic           last,
  output logic           busy
);

  localparam int unsigned CntW = $clog2(MSB);
  localparam logic [CntW-1:0] CntLast = CntW'(MSB - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e          state_q, state_d;
  logic [MSB-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;

  logic in_shift;
  logic accept;

  // Output decode: everything follows from the registered word state
  always_comb begin
    in_shift   = (state_q == StShift);
    busy       = in_shift;
    q_valid    = in_shift;
    last       = in_shift && (cnt_q == CntLast);
    // The final enabled beat frees the register for the next word
    load_ready = !in_shift || (en && last);
    q          = in_shift && (dir_q ? shreg_q[0] : shreg_q[MSB-1]);
    accept     = load_valid && load_ready;
  end

  // Next-state: load on accept, shift on enabled beats, drop to idle after last
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (accept) begin
      state_d = StShift;
      shreg_d = load_data;
      cnt_d   = '0;
      dir_d   = dir;
    end else if (in_shift && en) begin
      if (last) begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = dir_q ? {1'b0, shreg_q[MSB-1:1]} : {shreg_q[MSB-2:0], 1'b0};
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  // State registers; reset aborts any word in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed, table-driven bench for piso_shift_reg (MSB = 16).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_piso_shift_reg;

  logic        clk;
  logic        rstn;
  logic        en;
  logic        dir;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        q;
  logic        q_valid;
  logic        last;
  logic        busy;

  int n_checks;
  int n_err;

  typedef struct {
    string       name;
    logic        rstn;
    logic        en;
    logic        dir;
    logic        lv;
    logic [15:0] data;
    logic        eq;
    logic        eqv;
    logic        elast;
    logic        ebusy;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  piso_shift_reg #(
    .MSB(16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .dir       (dir),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .q         (q),
    .q_valid   (q_valid),
    .last      (last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic r, logic e, logic d, logic lv, logic [15:0] dat,
                              logic eq, logic eqv, logic el, logic eb, logic er);
    vec_t v;
    v.name = nm; v.rstn = r; v.en = e; v.dir = d; v.lv = lv; v.data = dat;
    v.eq = eq; v.eqv = eqv; v.elast = el; v.ebusy = eb; v.erdy = er;
    return v;
  endfunction

  // Idle cycle presenting a word: block must be idle and ready
  task automatic push_load(string nm, logic e, logic d, logic [15:0] dat);
    vecs.push_back(mk(nm, 1'b1, e, d, 1'b1, dat, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic push_idle(string nm, logic e);
    vecs.push_back(mk(nm, 1'b1, e, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // 16 enabled beats; dir input is d_lo before beat sw and d_hi from it on
  task automatic push_beats(string nm, logic [15:0] bits, logic d_lo, logic d_hi, int sw,
                            logic lv, logic [15:0] ldat);
    for (int b = 0; b < 16; b++) begin
      vecs.push_back(mk(nm, 1'b1, 1'b1, (b < sw) ? d_lo : d_hi, lv, ldat,
                        bits[15-b], 1'b1, b == 15, 1'b1, b == 15));
    end
  endtask

  task automatic chk(string nm, string sig, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %b expected %b at %0t", nm, sig, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    rstn       = v.rstn;
    en         = v.en;
    dir        = v.dir;
    load_valid = v.lv;
    load_data  = v.data;
    #1;
    chk(v.name, "q", q, v.eq);
    chk(v.name, "q_valid", q_valid, v.eqv);
    chk(v.name, "last", last, v.elast);
    chk(v.name, "busy", busy, v.ebusy);
    chk(v.name, "load_ready", load_ready, v.erdy);
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rstn       = 1'b0;
    en         = 1'b0;
    dir        = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;

    // Reset state, with load_valid high to show reset dominates
    vecs.push_back(mk("reset", 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Idle ignores en
    push_idle("idle_en", 1'b1);
    push_idle("idle_en", 1'b1);

    // A5C3 MSB-first
    push_load("msb_first", 1'b1, 1'b0, 16'hA5C3);
    push_beats("msb_first", 16'b1010010111000011, 1'b0, 1'b0, 16, 1'b0, 16'h0000);
    push_idle("msb_done", 1'b1);

    // A5C3 LSB-first
    push_load("lsb_first", 1'b1, 1'b1, 16'hA5C3);
    push_beats("lsb_first", 16'b1100001110100101, 1'b1, 1'b1, 16, 1'b0, 16'h0000);
    push_idle("lsb_done", 1'b1);

    // FFFF with en toggling 0/1: cnt = k/2, ready only on the enabled last beat
    push_load("en_toggle", 1'b0, 1'b0, 16'hFFFF);
    for (int k = 0; k < 32; k++) begin
      vecs.push_back(mk("en_toggle", 1'b1, k % 2 == 1, 1'b0, 1'b0, 16'h0000,
                        1'b1, 1'b1, k >= 30, 1'b1, k == 31));
    end
    push_idle("en_toggle_done", 1'b0);

    // Back-to-back: 0001 waits with valid high through 8001, accepted on its last beat
    push_load("b2b_w0", 1'b1, 1'b0, 16'h8001);
    push_beats("b2b_w0", 16'b1000000000000001, 1'b0, 1'b0, 16, 1'b1, 16'h0001);
    push_beats("b2b_w1", 16'b0000000000000001, 1'b0, 1'b0, 16, 1'b0, 16'h0000);
    push_idle("b2b_done", 1'b1);

    // dir flips at beat 5: word keeps the latched MSB-first order
    push_load("dir_flip", 1'b1, 1'b0, 16'hA5C3);
    push_beats("dir_flip", 16'b1010010111000011, 1'b0, 1'b1, 5, 1'b0, 16'h0000);
    push_load("dir_new", 1'b1, 1'b1, 16'hA5C3);
    push_beats("dir_new", 16'b1100001110100101, 1'b1, 1'b1, 16, 1'b0, 16'h0000);
    push_idle("dir_done", 1'b1);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-word: load A5C3, run beats 0..6, then drop rstn at beat 7
    apply(mk("rst_mid_load", 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5C3,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    begin
      logic [15:0] bits;
      bits = 16'b1010010111000011;
      for (int b = 0; b < 7; b++) begin
        apply(mk("rst_mid_beat", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000,
                 bits[15-b], 1'b1, 1'b0, 1'b1, 1'b0));
      end
    end
    // Outputs must clear within 1 ns of rstn falling, no clock edge needed
    apply(mk("rst_mid_async", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    apply(mk("rst_mid_held", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    apply(mk("rst_release", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.delete();
    push_load("post_rst", 1'b1, 1'b0, 16'h00FF);
    push_beats("post_rst", 16'b0000000011111111, 1'b0, 1'b0, 16, 1'b0, 16'h0000);
    push_idle("post_rst_done", 1'b1);
    foreach (vecs[i]) apply(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
